// File: rtl/jedro_1_alu_pkg.sv
// jedro_1_alu_pkg
//   Shared widths and ALU operation codes for the jedro_1 execute stage.
//   The op codes are {funct7[5], funct3} so the decoder can forward them
//   almost directly from the instruction word.
//   Contents: DATA_WIDTH, REG_ADDR_WIDTH, ALU_OP_WIDTH, ALU_OP_* codes,
//   shift direction enum, signed-overflow helper function.
package jedro_1_alu_pkg;

  localparam int DATA_WIDTH     = 32;
  localparam int REG_ADDR_WIDTH = 5;
  localparam int ALU_OP_WIDTH   = 4;

  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_ADD  = 4'b0000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SUB  = 4'b1000;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLL  = 4'b0001;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLT  = 4'b0010;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SLTU = 4'b0011;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_XOR  = 4'b0100;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRL  = 4'b0101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_SRA  = 4'b1101;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_OR   = 4'b0110;
  localparam logic [ALU_OP_WIDTH-1:0] ALU_OP_AND  = 4'b0111;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_e;

  // Two's-complement overflow from operand/result sign bits. For a
  // subtraction the effective second operand is -b, so its sign flips.
  function automatic logic signed_ovf(input logic a_msb, input logic b_msb,
                                      input logic r_msb, input logic is_sub);
    logic b_eff;
    b_eff = is_sub ? ~b_msb : b_msb;
    return (a_msb == b_eff) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/jedro_1_alu_shifter.sv
// jedro_1_alu_shifter
//   Combinational barrel shifter for SLL/SRL/SRA.
//   Ports:
//     data_i   in  DATA_WIDTH  value to shift
//     shamt_i  in  5           shift amount
//     dir_i    in  1           0 = left, 1 = right
//     arith_i  in  1           right shifts replicate the sign bit when set
//     res_o    out DATA_WIDTH  shifted value
module jedro_1_alu_shifter
  import jedro_1_alu_pkg::*;
(
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [4:0]            shamt_i,
  input  logic                  dir_i,
  input  logic                  arith_i,
  output logic [DATA_WIDTH-1:0] res_o
);

  // Select shift flavour; arith_i only matters for right shifts.
  always_comb begin
    res_o = '0;
    if (dir_i == SHIFT_LEFT) begin
      res_o = data_i << shamt_i;
    end else if (arith_i) begin
      res_o = DATA_WIDTH'($signed(data_i) >>> shamt_i);
    end else begin
      res_o = data_i >> shamt_i;
    end
  end

endmodule

// File: rtl/jedro_1_alu.sv
// jedro_1_alu
//   Registered integer ALU of the jedro_1 RV32I execute stage. Every output
//   is a flop, one cycle behind its inputs; a new op is accepted each cycle.
//   Optional build macro: JEDRO_1_ALU_OVERFLOW_EN enables signed overflow
//   detection for ADD/SUB; otherwise overflow_ro is held at 0.
//   Ports:
//     clk_i, rstn_i       clock, synchronous active-low reset
//     sel_i               operation select {funct7[5], funct3}
//     op_a_i, op_b_i      operands
//     dest_addr_i, wb_i   writeback tag, passed through unmodified
//     res_ro              registered result (also LSU address / JALR target)
//     ops_eq_ro           registered op_a_i == op_b_i, independent of sel_i
//     overflow_ro         registered signed overflow of ADD/SUB
//     dest_addr_ro, wb_ro registered writeback tag
module jedro_1_alu
  import jedro_1_alu_pkg::*;
(
  input  logic                      clk_i,
  input  logic                      rstn_i,
  input  logic [ALU_OP_WIDTH-1:0]   sel_i,
  input  logic [DATA_WIDTH-1:0]     op_a_i,
  input  logic [DATA_WIDTH-1:0]     op_b_i,
  input  logic [REG_ADDR_WIDTH-1:0] dest_addr_i,
  input  logic                      wb_i,
  output logic [DATA_WIDTH-1:0]     res_ro,
  output logic                      ops_eq_ro,
  output logic                      overflow_ro,
  output logic [REG_ADDR_WIDTH-1:0] dest_addr_ro,
  output logic                      wb_ro
);

  logic [DATA_WIDTH-1:0] sum;
  logic [DATA_WIDTH-1:0] diff;
  logic [DATA_WIDTH-1:0] shift_res;

  logic [DATA_WIDTH-1:0]     res_d,       res_q;
  logic                      ops_eq_d,    ops_eq_q;
  logic                      overflow_d,  overflow_q;
  logic [REG_ADDR_WIDTH-1:0] dest_addr_d, dest_addr_q;
  logic                      wb_d,        wb_q;

  assign sum  = op_a_i + op_b_i;
  assign diff = op_a_i - op_b_i;

  // sel_i[2] separates SLL (x001) from SRL/SRA (x101); sel_i[3] marks SRA.
  jedro_1_alu_shifter u_shifter (
    .data_i  (op_a_i),
    .shamt_i (op_b_i[4:0]),
    .dir_i   (sel_i[2]),
    .arith_i (sel_i[3]),
    .res_o   (shift_res)
  );

  // Opcode decode: result, overflow and pass-through next-state values.
  always_comb begin
    res_d       = '0;
    overflow_d  = 1'b0;
    ops_eq_d    = (op_a_i == op_b_i);
    dest_addr_d = dest_addr_i;
    wb_d        = wb_i;
    case (sel_i)
      ALU_OP_ADD: begin
        res_d = sum;
`ifdef JEDRO_1_ALU_OVERFLOW_EN
        overflow_d = signed_ovf(op_a_i[DATA_WIDTH-1], op_b_i[DATA_WIDTH-1],
                                sum[DATA_WIDTH-1], 1'b0);
`else
        overflow_d = 1'b0;
`endif
      end
      ALU_OP_SUB: begin
        res_d = diff;
`ifdef JEDRO_1_ALU_OVERFLOW_EN
        overflow_d = signed_ovf(op_a_i[DATA_WIDTH-1], op_b_i[DATA_WIDTH-1],
                                diff[DATA_WIDTH-1], 1'b1);
`else
        overflow_d = 1'b0;
`endif
      end
      ALU_OP_SLL,
      ALU_OP_SRL,
      ALU_OP_SRA:  res_d = shift_res;
      ALU_OP_SLT:  res_d = {{(DATA_WIDTH-1){1'b0}}, ($signed(op_a_i) < $signed(op_b_i))};
      ALU_OP_SLTU: res_d = {{(DATA_WIDTH-1){1'b0}}, (op_a_i < op_b_i)};
      ALU_OP_XOR:  res_d = op_a_i ^ op_b_i;
      ALU_OP_OR:   res_d = op_a_i | op_b_i;
      ALU_OP_AND:  res_d = op_a_i & op_b_i;
      default: begin
        res_d      = '0;
        overflow_d = 1'b0;
      end
    endcase
  end

  // Output registers; reset clears everything and wins over any op.
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      res_q       <= '0;
      ops_eq_q    <= 1'b0;
      overflow_q  <= 1'b0;
      dest_addr_q <= '0;
      wb_q        <= 1'b0;
    end else begin
      res_q       <= res_d;
      ops_eq_q    <= ops_eq_d;
      overflow_q  <= overflow_d;
      dest_addr_q <= dest_addr_d;
      wb_q        <= wb_d;
    end
  end

  assign res_ro       = res_q;
  assign ops_eq_ro    = ops_eq_q;
  assign overflow_ro  = overflow_q;
  assign dest_addr_ro = dest_addr_q;
  assign wb_ro        = wb_q;

endmodule

// File: tb/tb_jedro_1_alu.sv
// Self-checking bench for jedro_1_alu: a behavioural model predicts every
// registered output each cycle; directed steps pin literal expectations.
module tb_jedro_1_alu;
  import jedro_1_alu_pkg::*;

  logic        clk_i = 1'b0;
  logic        rstn_i;
  logic [3:0]  sel_i;
  logic [31:0] op_a_i, op_b_i;
  logic [4:0]  dest_addr_i;
  logic        wb_i;
  logic [31:0] res_ro;
  logic        ops_eq_ro, overflow_ro, wb_ro;
  logic [4:0]  dest_addr_ro;

  int checks = 0;
  int errors = 0;

`ifdef JEDRO_1_ALU_OVERFLOW_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  always #5 clk_i = ~clk_i;

  jedro_1_alu dut (
    .clk_i        (clk_i),
    .rstn_i       (rstn_i),
    .sel_i        (sel_i),
    .op_a_i       (op_a_i),
    .op_b_i       (op_b_i),
    .dest_addr_i  (dest_addr_i),
    .wb_i         (wb_i),
    .res_ro       (res_ro),
    .ops_eq_ro    (ops_eq_ro),
    .overflow_ro  (overflow_ro),
    .dest_addr_ro (dest_addr_ro),
    .wb_ro        (wb_ro)
  );

  // Reference: {overflow, result} from plain 64-bit signed/unsigned arithmetic.
  function automatic logic [32:0] alu_model(logic [3:0] s, logic [31:0] a, logic [31:0] b);
    longint sa, sb, ua, r;
    int     sh;
    logic [31:0] res;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'd0, a});
    sh  = int'(b % 32'd32);
    res = 32'd0;
    ovf = 1'b0;
    case (s)
      4'b0000: begin r = sa + sb; res = r[31:0];
                     ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'b1000: begin r = sa - sb; res = r[31:0];
                     ovf = (r > 64'sd2147483647) || (r < -64'sd2147483648); end
      4'b0001: begin r = ua * (64'sd1 <<< sh); res = r[31:0]; end
      4'b0010: res = (sa < sb) ? 32'd1 : 32'd0;
      4'b0011: res = (a < b) ? 32'd1 : 32'd0;
      4'b0100: res = a ^ b;
      4'b0101: begin r = ua / (64'sd1 <<< sh); res = r[31:0]; end
      4'b1101: begin r = sa >>> sh; res = r[31:0]; end
      4'b0110: res = a | b;
      4'b0111: res = a & b;
      default: res = 32'd0;
    endcase
    if (!OVF_ON) ovf = 1'b0;
    return {ovf, res};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected outputs, captured from the inputs at each rising edge.
  logic [31:0] exp_res;
  logic        exp_eq, exp_ovf, exp_wb, exp_valid;
  logic [4:0]  exp_dest;
  logic [32:0] m;
  initial exp_valid = 1'b0;

  always @(posedge clk_i) begin
    if (!rstn_i) begin
      exp_res <= 32'd0; exp_eq <= 1'b0; exp_ovf <= 1'b0; exp_dest <= 5'd0; exp_wb <= 1'b0;
    end else begin
      m = alu_model(sel_i, op_a_i, op_b_i);
      exp_res  <= m[31:0];
      exp_ovf  <= m[32];
      exp_eq   <= (op_a_i == op_b_i);
      exp_dest <= dest_addr_i;
      exp_wb   <= wb_i;
    end
    exp_valid <= 1'b1;
  end

  // Per-cycle comparison against the model, away from the rising edge.
  always @(negedge clk_i) begin
    if (exp_valid) begin
      chk("model_res",  res_ro,              exp_res);
      chk("model_eq",   {31'd0, ops_eq_ro},   {31'd0, exp_eq});
      chk("model_ovf",  {31'd0, overflow_ro}, {31'd0, exp_ovf});
      chk("model_dest", {27'd0, dest_addr_ro}, {27'd0, exp_dest});
      chk("model_wb",   {31'd0, wb_ro},       {31'd0, exp_wb});
    end
  end

  // Apply one op just after a falling edge, then wait until its result is visible.
  task automatic step(logic [3:0] s, logic [31:0] a, logic [31:0] b, logic [4:0] d, logic w);
    sel_i = s; op_a_i = a; op_b_i = b; dest_addr_i = d; wb_i = w;
    @(negedge clk_i);
    #1;
  endtask

  initial begin
    rstn_i = 1'b0; sel_i = 4'b0000; op_a_i = 32'd5; op_b_i = 32'd7;
    dest_addr_i = 5'd9; wb_i = 1'b1;
    repeat (3) @(negedge clk_i);
    #1;
    chk("rst_res", res_ro, 32'd0);
    chk("rst_wb", {31'd0, wb_ro}, 32'd0);
    chk("rst_dest", {27'd0, dest_addr_ro}, 32'd0);
    chk("rst_eq", {31'd0, ops_eq_ro}, 32'd0);
    rstn_i = 1'b1;
    step(4'b0000, 32'd5, 32'd7, 5'd9, 1'b1);
    chk("post_rst_res", res_ro, 32'd12);
    chk("post_rst_wb", {31'd0, wb_ro}, 32'd1);

    step(4'b0000, 32'hFFFF_FFFF, 32'd1, 5'd4, 1'b1);
    chk("add_wrap_res", res_ro, 32'd0);
    chk("add_wrap_ovf", {31'd0, overflow_ro}, 32'd0);
    step(4'b1000, 32'h8000_0000, 32'd1, 5'd4, 1'b1);
    chk("sub_wrap_res", res_ro, 32'h7FFF_FFFF);
    chk("sub_wrap_ovf", {31'd0, overflow_ro}, {31'd0, OVF_ON});
    step(4'b0000, 32'h7FFF_FFFF, 32'd1, 5'd4, 1'b1);
    chk("add_ovf", {31'd0, overflow_ro}, {31'd0, OVF_ON});
    step(4'b0010, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b0);
    chk("slt", res_ro, 32'd1);
    step(4'b0011, 32'hFFFF_FFFF, 32'd1, 5'd5, 1'b0);
    chk("sltu", res_ro, 32'd0);
    step(4'b0011, 32'h1234_5678, 32'h1234_5678, 5'd5, 1'b0);
    chk("eq", {31'd0, ops_eq_ro}, 32'd1);
    step(4'b1101, 32'h8000_0000, 32'h21, 5'd6, 1'b1);
    chk("sra", res_ro, 32'hC000_0000);
    step(4'b0101, 32'h8000_0000, 32'h21, 5'd6, 1'b1);
    chk("srl", res_ro, 32'h4000_0000);
    step(4'b0001, 32'h8000_0000, 32'h21, 5'd6, 1'b1);
    chk("sll", res_ro, 32'h0000_0000);
    step(4'b0101, 32'hA5A5_A5A5, 32'h20, 5'd6, 1'b1);
    chk("shift0", res_ro, 32'hA5A5_A5A5);

    step(4'b0100, 32'd1, 32'd2, 5'd1, 1'b1);
    chk("pipe1", {26'd0, wb_ro, dest_addr_ro}, {26'd0, 1'b1, 5'd1});
    step(4'b0110, 32'd3, 32'd4, 5'd2, 1'b0);
    chk("pipe2", {26'd0, wb_ro, dest_addr_ro}, {26'd0, 1'b0, 5'd2});
    step(4'b0111, 32'd5, 32'd6, 5'd3, 1'b1);
    chk("pipe3", {26'd0, wb_ro, dest_addr_ro}, {26'd0, 1'b1, 5'd3});

    step(4'b1111, 32'd3, 32'd3, 5'd7, 1'b1);
    chk("undef_res", res_ro, 32'd0);
    chk("undef_ovf", {31'd0, overflow_ro}, 32'd0);
    chk("undef_eq", {31'd0, ops_eq_ro}, 32'd1);
    chk("undef_wb", {31'd0, wb_ro}, 32'd1);

    for (int i = 0; i < 2000; i++) begin
      logic [3:0]  s;
      logic [31:0] a, b;
      s = 4'($urandom_range(0, 15));
      a = $urandom;
      case ($urandom_range(0, 7))
        0:       b = a;
        1:       b = 32'($urandom_range(0, 63));
        2:       b = {~a[31], a[30:0]};
        default: b = $urandom;
      endcase
      rstn_i = ($urandom_range(0, 63) != 0);
      step(s, a, b, 5'($urandom), 1'($urandom));
    end
    rstn_i = 1'b1;
    step(4'b0000, 32'd1, 32'd1, 5'd0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
